// File: rtl/lif_spike_generator_pkg.sv
// Shared types and constants for the spiking-neuron blocks.
package snn_pkg;

    // Width of the signed input current coming from the upstream accumulator.
    localparam int IC_W = 6;

    // Neuron FSM states.
    typedef enum logic {
        ST_INTEGRATE  = 1'b0,
        ST_REFRACTORY = 1'b1
    } lif_state_e;

endpackage

// File: rtl/lif_spike_generator_if.sv
// Timestep bus between the neuron core and its driver: per-step inputs in,
// spike / potential / refractory status out.
interface lif_spike_generator_if #(
    parameter int VW = 8,
    parameter int RW = 4
);
    import snn_pkg::*;

    logic                   enable;
    logic signed [IC_W-1:0] input_current;
    logic signed [VW-1:0]   threshold;
    logic [1:0]             decay;
    logic [RW-1:0]          refractory_period;
    logic                   spike_out;
    logic signed [VW-1:0]   membrane_potential;
    logic                   refractory;

    // Driver side: supplies the timestep stimulus.
    modport master (
        output enable, input_current, threshold, decay, refractory_period,
        input  spike_out, membrane_potential, refractory
    );

    // Neuron side.
    modport slave (
        input  enable, input_current, threshold, decay, refractory_period,
        output spike_out, membrane_potential, refractory
    );
endinterface

// File: rtl/lif_leak_unit.sv
// Combinational membrane update: leak by arithmetic shift, add the
// sign-extended input current one bit wider, then clamp back to VW bits.
module lif_leak_unit
    import snn_pkg::*;
#(
    parameter int VW = 8
) (
    input  logic signed [VW-1:0]   v_in,
    input  logic [1:0]             k,
    input  logic signed [IC_W-1:0] cur,
    output logic signed [VW-1:0]   v_next
);

    logic signed [VW-1:0] shifted;
    logic signed [VW-1:0] leaked;
    logic [VW:0]          sum;

    // Leak, widen, add and saturate; k=0 disables leak entirely.
    always_comb begin
        shifted = v_in >>> k;
        leaked  = (k == 2'd0) ? v_in : v_in - shifted;
        sum     = {leaked[VW-1], leaked} + {{(VW+1-IC_W){cur[IC_W-1]}}, cur};
        // Top two bits disagree only when the VW-bit result would wrap.
        if (sum[VW] != sum[VW-1])
            v_next = sum[VW] ? {1'b1, {(VW-1){1'b0}}} : {1'b0, {(VW-1){1'b1}}};
        else
            v_next = sum[VW-1:0];
    end

endmodule

// File: rtl/lif_spike_generator.sv
// Leaky integrate-and-fire neuron: one timestep per enable pulse, emits a
// one-cycle spike and then ignores a programmable number of timesteps.
module lif_spike_generator
    import snn_pkg::*;
#(
    parameter int VW = 8,
    parameter int RW = 4
) (
    input logic                 clk,
    input logic                 reset,
    lif_spike_generator_if.slave bus
);

    lif_state_e           state_q, state_d;
    logic signed [VW-1:0] v_q, v_d;
    logic [RW-1:0]        cnt_q, cnt_d;
    logic                 spike_q, spike_d;
    logic signed [VW-1:0] v_next;

    lif_leak_unit #(.VW(VW)) u_leak (
        .v_in   (v_q),
        .k      (bus.decay),
        .cur    (bus.input_current),
        .v_next (v_next)
    );

    // Next-state logic: without enable everything holds and the spike pulse drops.
    always_comb begin
        state_d = state_q;
        v_d     = v_q;
        cnt_d   = cnt_q;
        spike_d = 1'b0;
        if (bus.enable) begin
            case (state_q)
                ST_INTEGRATE: begin
                    if (v_next >= bus.threshold) begin
                        spike_d = 1'b1;
                        v_d     = '0;
                        if (bus.refractory_period != '0) begin
                            state_d = ST_REFRACTORY;
                            cnt_d   = bus.refractory_period;
                        end
                    end else begin
                        v_d = v_next;
                    end
                end
                ST_REFRACTORY: begin
                    // Current is ignored; the last ignored step returns to integrate.
                    v_d   = '0;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q <= 1)
                        state_d = ST_INTEGRATE;
                end
                default: state_d = ST_INTEGRATE;
            endcase
        end
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_INTEGRATE;
            v_q     <= '0;
            cnt_q   <= '0;
            spike_q <= 1'b0;
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            cnt_q   <= cnt_d;
            spike_q <= spike_d;
        end
    end

    assign bus.spike_out          = spike_q;
    assign bus.membrane_potential = v_q;
    assign bus.refractory         = (state_q == ST_REFRACTORY);

endmodule

// File: tb/tb_lif_spike_generator.sv
// Directed and randomized checks of the LIF neuron against an integer model.
module tb_lif_spike_generator;

    localparam int VW = 8;
    localparam int RW = 4;
    localparam int VMAX = (1 << (VW - 1)) - 1;
    localparam int VMIN = -(1 << (VW - 1));

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model state: potential, remaining ignored steps, last spike.
    int   m_v;
    int   m_left;
    bit   m_spk;
    int   thr_i, k_i, rp_i;

    lif_spike_generator_if #(.VW(VW), .RW(RW)) bus ();

    lif_spike_generator #(.VW(VW), .RW(RW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic int floor_div(int a, int d);
        if (a >= 0) return a / d;
        return -((-a + d - 1) / d);
    endfunction

    task automatic model_reset();
        m_v = 0; m_left = 0; m_spk = 0;
    endtask

    task automatic model_step(bit en, int cur);
        int lk, nx;
        m_spk = 0;
        if (!en) return;
        if (m_left > 0) begin
            m_v = 0;
            m_left--;
        end else begin
            lk = (k_i == 0) ? m_v : m_v - floor_div(m_v, 1 << k_i);
            nx = lk + cur;
            if (nx > VMAX) nx = VMAX;
            if (nx < VMIN) nx = VMIN;
            if (nx >= thr_i) begin
                m_spk = 1;
                m_v = 0;
                m_left = rp_i;
            end else begin
                m_v = nx;
            end
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // DUT outputs against the model.
    task automatic check_model(string tag);
        logic [7:0] ov, ev;
        ov = bus.membrane_potential;
        ev = m_v[7:0];
        chk({tag, ".v"}, {24'h0, ov}, {24'h0, ev});
        chk({tag, ".spk"}, {31'h0, bus.spike_out}, {31'h0, m_spk});
        chk({tag, ".ref"}, {31'h0, bus.refractory}, {31'h0, (m_left > 0)});
    endtask

    // DUT outputs against values worked out by hand.
    task automatic expect_out(string tag, int v, bit spk, bit rf);
        logic [7:0] ov, ev;
        ov = bus.membrane_potential;
        ev = v[7:0];
        chk({tag, ".v"}, {24'h0, ov}, {24'h0, ev});
        chk({tag, ".spk"}, {31'h0, bus.spike_out}, {31'h0, spk});
        chk({tag, ".ref"}, {31'h0, bus.refractory}, {31'h0, rf});
    endtask

    task automatic cfg(int thr, int k, int rp);
        thr_i = thr; k_i = k; rp_i = rp;
        bus.threshold = thr[7:0];
        bus.decay = k[1:0];
        bus.refractory_period = rp[3:0];
    endtask

    task automatic step(bit en, int cur);
        bus.enable = en;
        bus.input_current = cur[5:0];
        model_step(en, cur);
        @(posedge clk); #1;
        check_model("step");
    endtask

    task automatic do_reset();
        bus.enable = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        reset = 1'b1;
        bus.enable = 1'b0;
        bus.input_current = '0;
        cfg(20, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        expect_out("reset", 0, 0, 0);
        reset = 1'b0;

        // Plain integration, no leak, no refractory.
        cfg(20, 0, 0);
        step(1, 5);  expect_out("t1.s1", 5, 0, 0);
        step(1, 5);  expect_out("t1.s2", 10, 0, 0);
        step(1, 5);  expect_out("t1.s3", 15, 0, 0);
        step(1, 5);  expect_out("t1.s4", 0, 1, 0);

        // Refractory of two timesteps.
        do_reset();
        cfg(20, 0, 2);
        step(1, 31); expect_out("t2.s1", 0, 1, 1);
        step(1, 31); expect_out("t2.s2", 0, 0, 1);
        step(1, 31); expect_out("t2.s3", 0, 0, 0);
        step(1, 31); expect_out("t2.s4", 0, 1, 1);

        // Positive saturation then negative saturation.
        do_reset();
        cfg(127, 0, 0);
        step(1, 31); expect_out("t3.p1", 31, 0, 0);
        step(1, 31); expect_out("t3.p2", 62, 0, 0);
        step(1, 31); expect_out("t3.p3", 93, 0, 0);
        step(1, 31); expect_out("t3.p4", 124, 0, 0);
        step(1, 31); expect_out("t3.p5", 0, 1, 0);
        step(1, -32); expect_out("t3.n1", -32, 0, 0);
        step(1, -32); expect_out("t3.n2", -64, 0, 0);
        step(1, -32); expect_out("t3.n3", -96, 0, 0);
        step(1, -32); expect_out("t3.n4", -128, 0, 0);
        step(1, -32); expect_out("t3.n5", -128, 0, 0);
        // Negative potential leaks toward zero.
        cfg(127, 1, 0);
        step(1, 0); expect_out("t3.nl", -64, 0, 0);

        // Leak from 64 with k=1.
        do_reset();
        cfg(127, 0, 0);
        step(1, 31); step(1, 31); step(1, 2);
        expect_out("t4.pre", 64, 0, 0);
        cfg(127, 1, 0);
        step(1, 0); expect_out("t4.l1", 32, 0, 0);
        step(1, 0); expect_out("t4.l2", 16, 0, 0);
        step(1, 0); expect_out("t4.l3", 8, 0, 0);
        step(1, 0); expect_out("t4.l4", 4, 0, 0);
        step(1, 0); expect_out("t4.l5", 2, 0, 0);
        step(1, 0); expect_out("t4.l6", 1, 0, 0);
        step(1, 0); expect_out("t4.l7", 1, 0, 0);

        // Enable gaps during refractory and integration; async reset.
        do_reset();
        cfg(20, 0, 3);
        step(1, 31); expect_out("t5.spk", 0, 1, 1);
        step(1, 31); expect_out("t5.r1", 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 31); expect_out("t5.hold_r", 0, 0, 1);
        end
        step(1, 31); expect_out("t5.r2", 0, 0, 1);
        step(1, 31); expect_out("t5.r3", 0, 0, 0);
        step(1, 5);  expect_out("t5.int", 5, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 9); expect_out("t5.hold_i", 5, 0, 0);
        end
        step(1, 31); expect_out("t5.spk2", 0, 1, 1);
        step(1, 0);  expect_out("t5.r4", 0, 0, 1);
        reset = 1'b1;
        #2;
        expect_out("t5.async_rst", 0, 0, 0);
        reset = 1'b0;
        model_reset();
        step(1, 5); expect_out("t5.after", 5, 0, 0);

        // Randomized timesteps with occasionally non-positive thresholds.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            int thr, cur;
            logic [5:0] c6;
            thr = ($urandom_range(0, 9) == 0) ? -int'($urandom_range(0, 20))
                                              : int'($urandom_range(1, 127));
            cfg(thr, int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
            c6 = 6'($urandom);
            cur = int'($signed(c6));
            step($urandom_range(0, 3) != 0, cur);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
